bcd_adder_seq: RTL and testbench

- Parametrised, digit-serial, multi-digit BCD adder/subtractor; successor to the single-digit combinational BCD adder.
- Captures two DIGITS-wide packed-BCD operands on a start handshake and processes one digit per clock, least-significant digit first.
- Reports sum or difference, carry/no-borrow, and illegal-digit detection on completion.
- Sits between the datapath operand registers and display/accumulator logic.

---
 rtl/bcd_adder_seq.sv | 118 +++++++++++
 tb/tb_bcd_adder_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_adder_seq.sv
// Digit-serial multi-digit BCD adder/subtractor: one digit per clock, LSD first.
// Subtraction uses the nine's complement of Y with a forced carry-in of 1.
module bcd_adder_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   X,
    input  logic [4*DIGITS-1:0]   Y,
    input  logic                  c_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  c_out,
    output logic                  out_of_range
);

    // state  | meaning
    // S_IDLE | waiting for start; outputs hold the last completed operation
    // S_RUN  | one digit processed per clock, r_cnt counts down to the last digit
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

    state_t          r_state;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic [W-1:0]    r_acc;
    logic            r_sub;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic            r_oor;

    logic [3:0]      w_a;
    logic [3:0]      w_yd;
    logic [3:0]      w_b;
    logic [4:0]      w_t;
    logic            w_gt9;
    logic [3:0]      w_digit;
    logic [W+3:0]    w_shift;
    logic [W-1:0]    w_acc_next;
    logic            w_oor;

    always_comb begin
        w_oor = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (X[4*i +: 4] > 4'd9 || Y[4*i +: 4] > 4'd9)
                w_oor = 1'b1;
        end
    end

    // Operands shift right, so digit k is always in the low nibble during its cycle.
    assign w_a        = r_x[3:0];
    assign w_yd       = r_y[3:0];
    assign w_b        = r_sub ? (4'd9 - w_yd) : w_yd;
    assign w_t        = {1'b0, w_a} + {1'b0, w_b} + {4'b0000, r_carry};
    assign w_gt9      = (w_t > 5'd9);
    assign w_digit    = w_gt9 ? (w_t[3:0] + 4'd6) : w_t[3:0];
    assign w_shift    = {w_digit, r_acc};
    assign w_acc_next = w_shift[W+3:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_acc        <= '0;
            r_sub        <= 1'b0;
            r_carry      <= 1'b0;
            r_cnt        <= '0;
            r_oor        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            c_out        <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= X;
                        r_y     <= Y;
                        r_sub   <= sub;
                        r_carry <= sub ? 1'b1 : c_in;
                        r_oor   <= w_oor;
                        r_acc   <= '0;
                        r_cnt   <= LAST_CNT;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_x     <= r_x >> 4;
                    r_y     <= r_y >> 4;
                    r_acc   <= w_acc_next;
                    r_carry <= w_gt9;
                    if (r_cnt == '0) begin
                        result       <= w_acc_next;
                        c_out        <= w_gt9;
                        out_of_range <= r_oor;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_adder_seq.sv
// Self-checking bench for bcd_adder_seq (DIGITS=4): directed vectors, handshake
// corner cases, async reset abort, and randomized operations against a decimal model.
module tb_bcd_adder_seq;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          sub;
    logic          c_in;
    logic [15:0]   X;
    logic [15:0]   Y;
    logic          busy;
    logic          done;
    logic [15:0]   result;
    logic          c_out;
    logic          out_of_range;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bcd_adder_seq #(.DIGITS(D)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .X(X), .Y(Y),
        .c_in(c_in), .busy(busy), .done(done), .result(result),
        .c_out(c_out), .out_of_range(out_of_range)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        sub;
        logic        cin;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] res;
        logic        co;
        logic        oor;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Legal operands use decimal arithmetic; illegal digits follow the per-digit rule.
    task automatic model(input logic s, input logic ci, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic co, output logic oor);
        int p = 10 ** D;
        int sum;
        int carry;
        int a, b, t;
        oor = 1'b0;
        for (int k = 0; k < D; k++)
            if (x[4*k +: 4] > 9 || y[4*k +: 4] > 9) oor = 1'b1;
        if (!oor) begin
            sum = s ? (bcd2int(x) + p - bcd2int(y)) : (bcd2int(x) + bcd2int(y) + int'(ci));
            co  = (sum >= p);
            r   = int2bcd(sum % p);
        end else begin
            carry = s ? 1 : int'(ci);
            r = '0;
            for (int k = 0; k < D; k++) begin
                a = int'(x[4*k +: 4]);
                b = s ? ((9 - int'(y[4*k +: 4])) & 15) : int'(y[4*k +: 4]);
                t = a + b + carry;
                if (t > 9) begin
                    r[4*k +: 4] = 4'((t + 6) % 16);
                    carry = 1;
                end else begin
                    r[4*k +: 4] = 4'(t);
                    carry = 0;
                end
            end
            co = carry[0];
        end
    endtask

    // Called just after a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic s, input logic ci, input logic [15:0] x, input logic [15:0] y,
                          output int lat);
        X = x; Y = y; sub = s; c_in = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op_and_check(input string name, input logic s, input logic ci,
                                input logic [15:0] x, input logic [15:0] y);
        logic [15:0] er;
        logic eco, eoor;
        int lat;
        model(s, ci, x, y, er, eco, eoor);
        run_op(s, ci, x, y, lat);
        check({name, "_latency"}, lat, 4);
        check({name, "_result"}, result, er);
        check({name, "_c_out"}, c_out, eco);
        check({name, "_oor"}, out_of_range, eoor);
    endtask

    initial begin
        int lat;
        int t_done[3];
        int nd;
        int guard;
        logic [15:0] rx, ry;
        logic rs, rc;

        vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h9999, 16'h9999, 16'h9999, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'h1234, 16'h5000, 16'h6234, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 16'h1234, 16'h5000, 16'h6234, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 16'h000A, 16'h0000, 16'h0010, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 16'h4321, 16'h4321, 16'h0000, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; X = '0; Y = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_c_out", c_out, 0);
        check("rst_oor", out_of_range, 0);
        reset = 1'b0;
        @(negedge clk);

        // First op: check busy goes high right after the start edge.
        X = 16'h1234; Y = 16'h5678; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        lat = 0;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        check("first_latency", lat, 4);
        check("first_result", result, 16'h6912);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sub, vecs[i].cin, vecs[i].x, vecs[i].y, lat);
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_result", i), result, vecs[i].res);
            check($sformatf("vec%0d_c_out", i), c_out, vecs[i].co);
            check($sformatf("vec%0d_oor", i), out_of_range, vecs[i].oor);
        end
        @(negedge clk);

        // start held high: completions every DIGITS+1 cycles.
        X = 16'h0250; Y = 16'h0750; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        nd = 0; guard = 0;
        while (nd < 3 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (done) begin
                t_done[nd] = cyc;
                nd++;
                check("held_result", result, 16'h1000);
            end
        end
        start = 1'b0;
        check("held_count", nd, 3);
        if (nd == 3) begin
            check("held_interval0", t_done[1] - t_done[0], 5);
            check("held_interval1", t_done[2] - t_done[1], 5);
        end
        repeat (6) @(negedge clk);

        // start pulsed while busy with new operands: ignored.
        X = 16'h1234; Y = 16'h5678; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        X = 16'h1111; Y = 16'h2222; sub = 1'b1; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!done && guard < 20) begin @(negedge clk); guard++; end
        check("ignore_done_seen", done, 1);
        check("ignore_result", result, 16'h6912);
        check("ignore_c_out", c_out, 0);
        @(negedge clk);
        check("ignore_no_restart", busy, 0);

        // Start issued in the done cycle is accepted (run_op back-to-back).
        op_and_check("b2b_a", 1'b0, 1'b0, 16'h0045, 16'h0055);
        op_and_check("b2b_b", 1'b1, 1'b0, 16'h0100, 16'h0001);

        // Async reset two cycles into an operation.
        X = 16'h5000; Y = 16'h1234; sub = 1'b1; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_c_out", c_out, 0);
        check("arst_oor", out_of_range, 0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("arst_no_done", nd, 0);
        op_and_check("after_rst", 1'b1, 1'b0, 16'h5000, 16'h1234);

        // Randomized operations, mostly legal digits.
        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < D; k++) begin
                rx[4*k +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                ry[4*k +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            op_and_check($sformatf("rand%0d", i), rs, rc, rx, ry);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
